// File: rtl/jtag_shift_cmd_sched.sv
// jtag_shift_cmd_sched: command-FIFO sequencer for the JTAG shift engine; JTAG_SCHED_TIMEOUT_EN adds a watchdog
module jtag_shift_cmd_sched #(
  parameter int c_DATA_WIDTH = 32,
  parameter int c_LEN_WIDTH  = 16,
  parameter int c_MAX_LEN    = 4096,
  parameter int c_TMO_CYCLES = 1024
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    fifo_rempty,
  output logic                    fifo_r_en,
  input  logic [c_DATA_WIDTH-1:0] fifo_rd_data,
  output logic                    eng_start,
  output logic [1:0]              eng_op,
  output logic [c_LEN_WIDTH-1:0]  eng_len,
  output logic [c_DATA_WIDTH-1:0] tdi_data,
  output logic                    tdi_valid,
  input  logic                    tdi_ready,
  input  logic                    eng_done,
  output logic                    busy,
  output logic [15:0]             cmd_cnt,
  output logic                    err
);
  typedef enum logic [2:0] {IDLE, CMD_WAIT, DECODE, DATA_REQ, DATA_WAIT, DATA_HOLD, WAIT_DONE, DRAIN} state_t;
  localparam int c_LOG = $clog2(c_DATA_WIDTH);
  localparam logic [c_LEN_WIDTH-1:0] c_MAX = c_LEN_WIDTH'(c_MAX_LEN);
  state_t st, nxt;
  logic [c_LEN_WIDTH-1:0] wcnt, nw;
  logic [c_LEN_WIDTH:0] len_rnd;
  logic is_shift, too_long, len_zero, cmd_done, set_err, tmo_hit;
  assign len_rnd  = {1'b0, eng_len} + (c_LEN_WIDTH+1)'(c_DATA_WIDTH-1);
  assign nw       = c_LEN_WIDTH'(len_rnd >> c_LOG);
  assign is_shift = !eng_op[1];
  assign too_long = eng_len > c_MAX;
  assign len_zero = eng_len == '0;
`ifdef JTAG_SCHED_TIMEOUT_EN
  localparam int c_TW = $clog2(c_TMO_CYCLES+1);
  logic [c_TW-1:0] tmo;
  logic waiting;
  assign waiting = st == DATA_HOLD || st == WAIT_DONE;
  assign tmo_hit = (st == DATA_HOLD && !tdi_ready || st == WAIT_DONE && !eng_done) && tmo == c_TW'(c_TMO_CYCLES-1);
  always_ff @(posedge clk)
    if (rst || nxt != st || !waiting) tmo <= '0;
    else tmo <= tmo + 1'b1;
`else
  assign tmo_hit = 1'b0;
`endif
  always_ff @(posedge clk)
    if (rst) st <= IDLE;
    else st <= nxt;
  always_comb begin
    nxt = st;
    case (st)
      IDLE:      nxt = fifo_rempty ? IDLE : CMD_WAIT;
      CMD_WAIT:  nxt = DECODE;
      DECODE:    nxt = len_zero ? IDLE : (is_shift && too_long) ? DRAIN : is_shift ? DATA_REQ : WAIT_DONE;
      DATA_REQ:  nxt = fifo_rempty ? DATA_REQ : DATA_WAIT;
      DATA_WAIT: nxt = DATA_HOLD;
      DATA_HOLD: nxt = tmo_hit ? IDLE : !tdi_ready ? DATA_HOLD : (wcnt + 1'b1 < nw) ? DATA_REQ : WAIT_DONE;
      WAIT_DONE: nxt = (eng_done || tmo_hit) ? IDLE : WAIT_DONE;
      DRAIN:     nxt = (wcnt == nw) ? IDLE : DRAIN;
      default:   nxt = IDLE;
    endcase
  end
  always_comb begin
    fifo_r_en = !fifo_rempty && (st == IDLE || st == DATA_REQ || (st == DRAIN && wcnt != nw));
    eng_start = st == DECODE && !len_zero && !(is_shift && too_long);
    tdi_valid = st == DATA_HOLD;
    busy      = st != IDLE;
    cmd_done  = (st == DECODE && len_zero) || (st == WAIT_DONE && eng_done);
    set_err   = (st == DECODE && !len_zero && is_shift && too_long) || (eng_done && st != WAIT_DONE) || tmo_hit;
  end
  always_ff @(posedge clk)
    if (rst) begin
      eng_op   <= '0;
      eng_len  <= '0;
      tdi_data <= '0;
      wcnt     <= '0;
      cmd_cnt  <= '0;
      err      <= 1'b0;
    end else begin
      if (st == CMD_WAIT) begin
        eng_op  <= fifo_rd_data[c_DATA_WIDTH-1:c_DATA_WIDTH-2];
        eng_len <= fifo_rd_data[c_LEN_WIDTH-1:0];
      end
      if (st == DECODE) wcnt <= '0;
      if (st == DATA_WAIT) tdi_data <= fifo_rd_data;
      if ((st == DATA_HOLD && tdi_ready) || (st == DRAIN && fifo_r_en)) wcnt <= wcnt + 1'b1;
      if (cmd_done) cmd_cnt <= cmd_cnt + 1'b1;
      if (set_err) err <= 1'b1;
    end
endmodule
